pll_lock_monitor: RTL and testbench

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

---
 rtl/pll_lock_monitor.sv | 173 +++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_monitor.sv
// rtl/pll_lock_monitor.sv - PLL lock qualification, loss accounting and reset/retry sequencing
module pll_lock_monitor #(
    parameter int NUM_CH        = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       lock_in,
    input  logic                    clr_err,
    output logic                    pll_rst_req,
    output logic [NUM_CH-1:0]       ch_locked,
    output logic                    all_locked,
    output logic [NUM_CH*CNT_W-1:0] loss_cnt,
    output logic [NUM_CH-1:0]       err,
    output logic                    fail
);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    localparam int SCNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int RCNT_W = $clog2(RST_CYCLES + 1);
    localparam int TCNT_W = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [SCNT_W-1:0] STABLE_MAX   = SCNT_W'(STABLE_CYCLES);
    localparam logic [SCNT_W-1:0] STABLE_LAST  = SCNT_W'(STABLE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RST_LAST     = RCNT_W'(RST_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]        RETRY_MAX    = 4'(MAX_RETRY);
    localparam logic [CNT_W-1:0]  LOSS_MAX     = '1;
    localparam logic [CNT_W-1:0]  LOSS_ONE     = CNT_W'(1);

    state_t              state;
    logic [NUM_CH-1:0]   sync_q1;
    logic [NUM_CH-1:0]   sync_q2;
    logic [SCNT_W-1:0]   stable_cnt [NUM_CH];
    logic [RCNT_W-1:0]   rst_timer;
    logic [TCNT_W-1:0]   tout_cnt;
    logic [3:0]          retry_cnt;
    logic [NUM_CH-1:0]   loss_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= lock_in;
            sync_q2 <= sync_q1;
        end
    end

    // Qualification restarts whenever the PLL is held in reset, so a lock must be re-earned afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stable_cnt[i] <= '0;
            end
            ch_locked <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (state == ST_RESET || !sync_q2[i]) begin
                    stable_cnt[i] <= '0;
                    ch_locked[i]  <= 1'b0;
                end else if (stable_cnt[i] != STABLE_MAX) begin
                    stable_cnt[i] <= stable_cnt[i] + 1'b1;
                    if (stable_cnt[i] == STABLE_LAST) begin
                        ch_locked[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign loss_evt = (state == ST_LOCKED) ? (ch_locked & ~sync_q2) : '0;

    // A loss in the same cycle as clr_err survives the clear and counts as the first loss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err      <= '0;
            loss_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (loss_evt[i]) begin
                    err[i] <= 1'b1;
                    if (clr_err) begin
                        loss_cnt[i*CNT_W +: CNT_W] <= LOSS_ONE;
                    end else if (loss_cnt[i*CNT_W +: CNT_W] != LOSS_MAX) begin
                        loss_cnt[i*CNT_W +: CNT_W] <= loss_cnt[i*CNT_W +: CNT_W] + 1'b1;
                    end
                end else if (clr_err) begin
                    err[i]                     <= 1'b0;
                    loss_cnt[i*CNT_W +: CNT_W] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RESET;
            pll_rst_req <= 1'b1;
            all_locked  <= 1'b0;
            fail        <= 1'b0;
            rst_timer   <= '0;
            tout_cnt    <= '0;
            retry_cnt   <= '0;
        end else begin
            case (state)
                ST_RESET: begin
                    if (rst_timer == RST_LAST) begin
                        state       <= ST_WAIT_LOCK;
                        pll_rst_req <= 1'b0;
                        rst_timer   <= '0;
                        tout_cnt    <= '0;
                    end else begin
                        rst_timer <= rst_timer + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (&ch_locked) begin
                        state      <= ST_LOCKED;
                        all_locked <= 1'b1;
                        retry_cnt  <= '0;
                    end else if (tout_cnt == TIMEOUT_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state       <= ST_RESET;
                            pll_rst_req <= 1'b1;
                            rst_timer   <= '0;
                            retry_cnt   <= retry_cnt + 4'd1;
                        end
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (|loss_evt) begin
                        state       <= ST_RESET;
                        all_locked  <= 1'b0;
                        pll_rst_req <= 1'b1;
                        rst_timer   <= '0;
                    end
                end
                ST_FAIL: begin
                    if (clr_err) begin
                        state       <= ST_RESET;
                        fail        <= 1'b0;
                        retry_cnt   <= '0;
                        pll_rst_req <= 1'b1;
                        rst_timer   <= '0;
                    end
                end
                default: begin
                    state       <= ST_RESET;
                    pll_rst_req <= 1'b1;
                    all_locked  <= 1'b0;
                    rst_timer   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// tb/tb_pll_lock_monitor.sv - directed self-checking bench for pll_lock_monitor
module tb_pll_lock_monitor;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       lock_in = '0;
    logic                    clr_err = 1'b0;
    logic                    pll_rst_req;
    logic [NUM_CH-1:0]       ch_locked;
    logic                    all_locked;
    logic [NUM_CH*CNT_W-1:0] loss_cnt;
    logic [NUM_CH-1:0]       err;
    logic                    fail;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_monitor #(
        .NUM_CH(NUM_CH),
        .STABLE_CYCLES(8),
        .RST_CYCLES(4),
        .LOCK_TIMEOUT(64),
        .MAX_RETRY(2),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lock_in(lock_in),
        .clr_err(clr_err),
        .pll_rst_req(pll_rst_req),
        .ch_locked(ch_locked),
        .all_locked(all_locked),
        .loss_cnt(loss_cnt),
        .err(err),
        .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_len(output int len);
        len = 0;
        while (pll_rst_req === 1'b1 && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_len(output int len);
        len = 0;
        while (pll_rst_req === 1'b0 && fail === 1'b0 && len < 200) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_locked(input string tag, input int budget);
        int k;
        k = 0;
        while (all_locked !== 1'b1 && k < budget) begin
            k++;
            @(negedge clk);
        end
        check(tag, all_locked, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len;

        step(3);
        check("rst_pll_rst_req", pll_rst_req, 1);
        check("rst_ch_locked", ch_locked, 0);
        check("rst_all_locked", all_locked, 0);
        check("rst_err", err, 0);
        check("rst_loss_cnt", loss_cnt, 0);
        check("rst_fail", fail, 0);

        // Lock-up after reset release
        rst = 1'b0;
        pulse_len(len);
        check("lockup_pulse_len", len, 4);
        step(1);
        lock_in = 2'b11;
        step(9);
        check("lockup_ch_locked_early", ch_locked, 2'b00);
        step(1);
        check("lockup_ch_locked", ch_locked, 2'b11);
        check("lockup_all_locked_early", all_locked, 0);
        step(1);
        check("lockup_all_locked", all_locked, 1);
        check("lockup_err", err, 0);

        // Loss on channel 1 while locked
        lock_in = 2'b01;
        step(2);
        check("loss_still_locked", all_locked, 1);
        step(1);
        check("loss_err", err, 2'b10);
        check("loss_cnt_ch1", loss_cnt, 8'h10);
        check("loss_all_locked", all_locked, 0);
        check("loss_pll_rst_req_c1", pll_rst_req, 1);
        step(1);
        check("loss_pll_rst_req_c2", pll_rst_req, 1);
        step(1);
        check("loss_pll_rst_req_c3", pll_rst_req, 1);
        lock_in = 2'b11;
        step(1);
        check("loss_pll_rst_req_c4", pll_rst_req, 1);
        step(1);
        check("loss_pll_rst_req_end", pll_rst_req, 0);
        step(7);
        check("relock_ch_early", ch_locked, 2'b00);
        step(1);
        check("relock_ch_locked", ch_locked, 2'b11);
        step(1);
        check("relock_all_locked", all_locked, 1);
        check("relock_err_kept", err, 2'b10);
        check("relock_loss_kept", loss_cnt, 8'h10);

        // Mid-operation reset from LOCKED
        lock_in = 2'b10;
        rst = 1'b1;
        #1;
        check("mrst_pll_rst_req", pll_rst_req, 1);
        check("mrst_ch_locked", ch_locked, 0);
        check("mrst_all_locked", all_locked, 0);
        check("mrst_err", err, 0);
        check("mrst_loss_cnt", loss_cnt, 0);
        check("mrst_fail", fail, 0);
        step(1);
        rst = 1'b0;
        pulse_len(len);
        check("mrst_pulse_len", len, 4);

        // Glitch on channel 0 during WAIT_LOCK
        lock_in = 2'b11;
        step(6);
        lock_in = 2'b10;
        step(1);
        lock_in = 2'b11;
        step(9);
        check("glitch_ch0_early", ch_locked, 2'b10);
        step(1);
        check("glitch_ch0_locked", ch_locked, 2'b11);
        step(1);
        check("glitch_all_locked", all_locked, 1);
        check("glitch_err", err, 0);

        // Loss counter saturation on channel 0
        for (int i = 0; i < 20; i++) begin
            lock_in = 2'b10;
            step(3);
            lock_in = 2'b11;
            wait_locked("sat_relock", 40);
        end
        check("sat_loss_cnt", loss_cnt, 8'h0F);
        check("sat_err", err, 2'b01);

        // clr_err coincident with a loss: the loss wins
        lock_in = 2'b10;
        step(2);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("prio_loss_cnt", loss_cnt, 8'h01);
        check("prio_err", err, 2'b01);
        check("prio_pll_rst_req", pll_rst_req, 1);
        lock_in = 2'b11;
        wait_locked("prio_relock", 40);

        // clr_err while locked clears errors without leaving LOCKED
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("clr_err_locked", err, 0);
        check("clr_loss_locked", loss_cnt, 0);
        check("clr_stays_locked", all_locked, 1);

        // Retry exhaustion with lock held low
        lock_in = 2'b00;
        step(3);
        check("exh_err", err, 2'b11);
        check("exh_loss_cnt", loss_cnt, 8'h11);
        for (int p = 0; p < 3; p++) begin
            pulse_len(len);
            check("exh_pulse_len", len, 4);
            wait_len(len);
            check("exh_wait_len", len, 64);
        end
        check("exh_fail", fail, 1);
        check("exh_pll_rst_req", pll_rst_req, 0);
        check("exh_all_locked", all_locked, 0);
        step(5);
        check("exh_fail_sticky", fail, 1);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        check("clr_fail", fail, 0);
        check("clr_fail_pll_rst_req", pll_rst_req, 1);
        check("clr_fail_err", err, 0);
        check("clr_fail_loss_cnt", loss_cnt, 0);
        pulse_len(len);
        check("clr_pulse_len", len, 4);
        wait_len(len);
        check("clr_wait_len", len, 64);
        check("clr_retry_reset", pll_rst_req, 1);
        check("clr_no_refail", fail, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
